// File: rtl/reg_ring_initiator.sv
// rtl/reg_ring_initiator.sv - register ring head: issues one host command per round trip and terminates returns
module reg_ring_initiator #(
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int REG_ADDR_WIDTH    = 23,
    parameter int REG_DATA_WIDTH    = 32,
    parameter int SRC_ID            = 0,
    parameter int TIMEOUT           = 127
) (
    input  logic                         clk,
    input  logic                         reset,
    // host command side
    input  logic                         cmd_req,
    input  logic                         cmd_rd_wr_L,
    input  logic [REG_ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [REG_DATA_WIDTH-1:0]    cmd_wr_data,
    output logic                         cmd_rdy,
    // host response side
    output logic                         rsp_valid,
    output logic [REG_DATA_WIDTH-1:0]    rsp_data,
    output logic [1:0]                   rsp_status,
    // ring head
    output logic                         reg_req_out,
    output logic                         reg_ack_out,
    output logic                         reg_rd_wr_L_out,
    output logic [REG_ADDR_WIDTH-1:0]    reg_addr_out,
    output logic [REG_DATA_WIDTH-1:0]    reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
    // ring tail
    input  logic                         reg_req_in,
    input  logic                         reg_ack_in,
    input  logic                         reg_rd_wr_L_in,
    input  logic [REG_ADDR_WIDTH-1:0]    reg_addr_in,
    input  logic [REG_DATA_WIDTH-1:0]    reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
    output logic [7:0]                   stray_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG  = UDP_REG_SRC_WIDTH'(SRC_ID);
    localparam logic [REG_DATA_WIDTH-1:0]    ERR_DATA = REG_DATA_WIDTH'(32'hDEAD_BEEF);
    localparam logic [8:0]                   TMO_VAL  = 9'(TIMEOUT);

    state_t                         state_q;
    logic                           rd_wr_L_q;
    logic [REG_ADDR_WIDTH-1:0]      addr_q;
    logic [REG_DATA_WIDTH-1:0]      wr_data_q;
    logic [7:0]                     timer_q;
    logic                           cmd_rdy_q;
    logic                           rsp_valid_q;
    logic [REG_DATA_WIDTH-1:0]      rsp_data_q;
    logic [1:0]                     rsp_status_q;
    logic                           reg_req_out_q;
    logic                           reg_rd_wr_L_out_q;
    logic [REG_ADDR_WIDTH-1:0]      reg_addr_out_q;
    logic [REG_DATA_WIDTH-1:0]      reg_data_out_q;
    logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out_q;
    logic [7:0]                     stray_cnt_q;
    logic [7:0]                     stray_cnt_d;

    logic       match;
    logic [8:0] timer_inc;
    logic       timeout_hit;
    logic       unused_ring_rd_wr_L;

    // The return's direction bit carries nothing we need; the latched command decides.
    assign unused_ring_rd_wr_L = reg_rd_wr_L_in;

    assign match       = reg_req_in && (reg_src_in == SRC_TAG) && (reg_addr_in == addr_q);
    assign timer_inc   = {1'b0, timer_q} + 9'd1;
    assign timeout_hit = (timer_inc == TMO_VAL);

    // Main transaction FSM; every host and ring output is a register set here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            rd_wr_L_q         <= 1'b0;
            addr_q            <= '0;
            wr_data_q         <= '0;
            timer_q           <= '0;
            cmd_rdy_q         <= 1'b1;
            rsp_valid_q       <= 1'b0;
            rsp_data_q        <= '0;
            rsp_status_q      <= 2'b00;
            reg_req_out_q     <= 1'b0;
            reg_rd_wr_L_out_q <= 1'b0;
            reg_addr_out_q    <= '0;
            reg_data_out_q    <= '0;
            reg_src_out_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_req) begin
                        rd_wr_L_q         <= cmd_rd_wr_L;
                        addr_q            <= cmd_addr;
                        wr_data_q         <= cmd_wr_data;
                        cmd_rdy_q         <= 1'b0;
                        reg_req_out_q     <= 1'b1;
                        reg_rd_wr_L_out_q <= cmd_rd_wr_L;
                        reg_addr_out_q    <= cmd_addr;
                        reg_data_out_q    <= cmd_rd_wr_L ? '0 : cmd_wr_data;
                        reg_src_out_q     <= SRC_TAG;
                        state_q           <= ISSUE;
                    end
                end
                ISSUE: begin
                    reg_req_out_q     <= 1'b0;
                    reg_rd_wr_L_out_q <= 1'b0;
                    reg_addr_out_q    <= '0;
                    reg_data_out_q    <= '0;
                    reg_src_out_q     <= '0;
                    timer_q           <= '0;
                    state_q           <= WAIT;
                end
                WAIT: begin
                    // A match in the same cycle as the timer expiry takes priority.
                    if (match) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= reg_ack_in ? 2'b00 : 2'b01;
                        rsp_data_q   <= !reg_ack_in ? ERR_DATA :
                                        (rd_wr_L_q ? reg_data_in : wr_data_q);
                        state_q      <= RESP;
                    end else if (timeout_hit) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_status_q <= 2'b10;
                        rsp_data_q   <= ERR_DATA;
                        state_q      <= RESP;
                    end else begin
                        timer_q <= timer_inc[7:0];
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    cmd_rdy_q   <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    cmd_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    // Any return that is not the awaited match is dropped and counted, saturating.
    always_comb begin
        stray_cnt_d = stray_cnt_q;
        if (reg_req_in && !((state_q == WAIT) && match) && (stray_cnt_q != 8'hFF)) begin
            stray_cnt_d = stray_cnt_q + 8'd1;
        end
    end

    // Stray counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stray_cnt_q <= '0;
        end else begin
            stray_cnt_q <= stray_cnt_d;
        end
    end

    assign cmd_rdy         = cmd_rdy_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_status      = rsp_status_q;
    assign reg_req_out     = reg_req_out_q;
    assign reg_ack_out     = 1'b0;
    assign reg_rd_wr_L_out = reg_rd_wr_L_out_q;
    assign reg_addr_out    = reg_addr_out_q;
    assign reg_data_out    = reg_data_out_q;
    assign reg_src_out     = reg_src_out_q;
    assign stray_cnt       = stray_cnt_q;

endmodule

// File: tb/tb_reg_ring_initiator.sv
// tb/tb_reg_ring_initiator.sv - scoreboard bench for reg_ring_initiator
module tb_reg_ring_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_req = 1'b0;
    logic        cmd_rd_wr_L = 1'b0;
    logic [22:0] cmd_addr = '0;
    logic [31:0] cmd_wr_data = '0;
    logic        cmd_rdy;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        reg_req_out;
    logic        reg_ack_out;
    logic        reg_rd_wr_L_out;
    logic [22:0] reg_addr_out;
    logic [31:0] reg_data_out;
    logic [1:0]  reg_src_out;
    logic        reg_req_in = 1'b0;
    logic        reg_ack_in = 1'b0;
    logic        reg_rd_wr_L_in = 1'b0;
    logic [22:0] reg_addr_in = '0;
    logic [31:0] reg_data_in = '0;
    logic [1:0]  reg_src_in = '0;
    logic [7:0]  stray_cnt;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  status;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    reg_ring_initiator #(.TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .cmd_req(cmd_req), .cmd_rd_wr_L(cmd_rd_wr_L), .cmd_addr(cmd_addr),
        .cmd_wr_data(cmd_wr_data), .cmd_rdy(cmd_rdy),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
        .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
        .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
        .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
        .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
        .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe is popped against the scoreboard.
    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected data=0x%0h status=%b expected no response", rsp_data, rsp_status);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_status", 64'(rsp_status), 64'(e.status));
            end
        end
    end

    task automatic issue_cmd(input logic rw, input logic [22:0] a, input logic [31:0] d);
        int i;
        for (i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cmd_rdy) break;
        end
        if (i == 30) chk("cmd_rdy_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        cmd_req = 1'b1; cmd_rd_wr_L = rw; cmd_addr = a; cmd_wr_data = d;
        @(posedge clk); #1;
        cmd_req = 1'b0;
    endtask

    // Ends at the negedge of the ISSUE cycle.
    task automatic check_issue(input logic rw, input logic [22:0] a, input logic [31:0] d);
        int i;
        for (i = 0; i < 5; i++) begin
            @(negedge clk);
            if (reg_req_out) break;
        end
        chk("issue_req", 64'(reg_req_out), 64'(1));
        chk("issue_ack", 64'(reg_ack_out), 64'(0));
        chk("issue_rw", 64'(reg_rd_wr_L_out), 64'(rw));
        chk("issue_addr", 64'(reg_addr_out), 64'(a));
        chk("issue_data", 64'(reg_data_out), 64'(rw ? 32'h0 : d));
        chk("issue_src", 64'(reg_src_out), 64'(0));
    endtask

    task automatic check_after_issue();
        @(negedge clk);
        chk("post_issue_req", 64'(reg_req_out), 64'(0));
        chk("post_issue_addr", 64'(reg_addr_out), 64'(0));
        chk("post_issue_data", 64'(reg_data_out), 64'(0));
    endtask

    task automatic ring_return(input int delay, input logic ack, input logic [1:0] src,
                               input logic [22:0] a, input logic [31:0] d);
        repeat (delay) @(posedge clk);
        #1;
        reg_req_in = 1'b1; reg_ack_in = ack; reg_src_in = src;
        reg_addr_in = a; reg_data_in = d; reg_rd_wr_L_in = 1'b1;
        @(posedge clk); #1;
        reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_src_in = '0;
        reg_addr_in = '0; reg_data_in = '0; reg_rd_wr_L_in = 1'b0;
    endtask

    task automatic wait_rsp();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        if (i == 40) chk("rsp_wait_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int n;
        int extra;
        exp_t e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_status", 64'(rsp_status), 64'(0));
        chk("rst_req_out", 64'(reg_req_out), 64'(0));
        chk("rst_stray", 64'(stray_cnt), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;

        // Write acked after 5 cycles
        e.data = 32'h1234_5678; e.status = 2'b00; exp_q.push_back(e);
        issue_cmd(1'b0, 23'h000100, 32'h1234_5678);
        check_issue(1'b0, 23'h000100, 32'h1234_5678);
        check_after_issue();
        ring_return(5, 1'b1, 2'd0, 23'h000100, 32'h0BAD_0BAD);
        wait_rsp();
        @(negedge clk);
        chk("rsp_valid_one_cycle", 64'(rsp_valid), 64'(0));
        chk("rsp_data_hold", 64'(rsp_data), 64'(32'h1234_5678));
        chk("cmd_rdy_after_rsp", 64'(cmd_rdy), 64'(1));

        // Read acked with immediate return
        e.data = 32'hCAFE_F00D; e.status = 2'b00; exp_q.push_back(e);
        issue_cmd(1'b1, 23'h000200, 32'hFFFF_FFFF);
        check_issue(1'b1, 23'h000200, 32'hFFFF_FFFF);
        check_after_issue();
        ring_return(0, 1'b1, 2'd0, 23'h000200, 32'hCAFE_F00D);
        wait_rsp();

        // Read not acked at top address
        e.data = 32'hDEAD_BEEF; e.status = 2'b01; exp_q.push_back(e);
        issue_cmd(1'b1, 23'h7FFFFF, 32'h0);
        check_issue(1'b1, 23'h7FFFFF, 32'h0);
        check_after_issue();
        ring_return(3, 1'b0, 2'd0, 23'h7FFFFF, 32'h1111_1111);
        wait_rsp();

        // Timeout with a command attempted during WAIT
        e.data = 32'hDEAD_BEEF; e.status = 2'b10; exp_q.push_back(e);
        issue_cmd(1'b1, 23'h000040, 32'h0);
        check_issue(1'b1, 23'h000040, 32'h0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                chk("cmd_rdy_in_wait", 64'(cmd_rdy), 64'(0));
                cmd_req = 1'b1; cmd_rd_wr_L = 1'b0; cmd_addr = 23'h000555; cmd_wr_data = 32'h5555_5555;
            end
            if (n == 4) cmd_req = 1'b0;
            if (rsp_valid) break;
        end
        chk("timeout_latency", 64'(n), 64'(11));
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (reg_req_out) extra++;
        end
        chk("ignored_cmd_no_issue", 64'(extra), 64'(0));
        chk("idle_after_timeout", 64'(cmd_rdy), 64'(1));

        // Wrong-source return in WAIT, then the true return
        e.data = 32'hA5A5_A5A5; e.status = 2'b00; exp_q.push_back(e);
        issue_cmd(1'b1, 23'h000300, 32'h0);
        check_issue(1'b1, 23'h000300, 32'h0);
        check_after_issue();
        ring_return(1, 1'b1, 2'd1, 23'h000300, 32'h0000_0001);
        ring_return(1, 1'b1, 2'd0, 23'h000300, 32'hA5A5_A5A5);
        wait_rsp();
        @(negedge clk);
        chk("stray_wrong_src", 64'(stray_cnt), 64'(1));

        // 300 strays in IDLE saturate the counter
        @(posedge clk); #1;
        reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_src_in = 2'd0; reg_addr_in = 23'h0; reg_data_in = 32'h0;
        repeat (300) @(posedge clk);
        #1;
        reg_req_in = 1'b0; reg_ack_in = 1'b0;
        @(negedge clk);
        chk("stray_saturate", 64'(stray_cnt), 64'(255));
        chk("idle_after_strays", 64'(cmd_rdy), 64'(1));

        // Reset during WAIT aborts; late return counts as stray
        issue_cmd(1'b0, 23'h000400, 32'h4444_4444);
        check_issue(1'b0, 23'h000400, 32'h4444_4444);
        check_after_issue();
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("async_rst_stray", 64'(stray_cnt), 64'(0));
        chk("async_rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        ring_return(1, 1'b1, 2'd0, 23'h000400, 32'h4444_4444);
        repeat (5) @(negedge clk);
        chk("late_return_stray", 64'(stray_cnt), 64'(1));
        chk("cmd_rdy_after_abort", 64'(cmd_rdy), 64'(1));

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_ring_initiator.md
REG_RING_INITIATOR -- requirements
Module: reg_ring_initiator

Interface
REQ-001 SHALL have parameter UDP_REG_SRC_WIDTH, default 2, width of the ring source tag.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 23, width of ring and command address.
REQ-003 SHALL have parameter REG_DATA_WIDTH, default 32, width of ring and command data.
REQ-004 SHALL have parameter SRC_ID, default 0, source tag stamped on issued requests and matched on return.
REQ-005 SHALL have parameter TIMEOUT, default 127, WAIT cycles before a timeout response (legal range 1..255).
REQ-006 SHALL have one clock and an asynchronous, active-low reset; ports: clk in 1 (rising-edge clock); reset in 1 (asynchronous, active-low).
REQ-007 SHALL have ports: cmd_req in 1 (host command strobe); cmd_rd_wr_L in 1 (1=read, 0=write); cmd_addr in REG_ADDR_WIDTH; cmd_wr_data in REG_DATA_WIDTH; cmd_rdy out 1 (initiator idle).
REQ-008 SHALL have ports: rsp_valid out 1 (one-cycle response strobe); rsp_data out REG_DATA_WIDTH; rsp_status out 2 (00 acked, 01 no-ack, 10 timeout).
REQ-009 SHALL have ring-head outputs: reg_req_out 1, reg_ack_out 1, reg_rd_wr_L_out 1, reg_addr_out REG_ADDR_WIDTH, reg_data_out REG_DATA_WIDTH, reg_src_out UDP_REG_SRC_WIDTH.
REQ-010 SHALL have ring-tail inputs: reg_req_in 1, reg_ack_in 1, reg_rd_wr_L_in 1, reg_addr_in REG_ADDR_WIDTH, reg_data_in REG_DATA_WIDTH, reg_src_in UDP_REG_SRC_WIDTH.
REQ-011 SHALL have output stray_cnt 8 (saturating count of discarded ring returns).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-013 IDLE: cmd_rdy=1; cmd_req=1 SHALL latch rd_wr_L/addr/wr_data and move to ISSUE next cycle.
REQ-014 cmd_req while cmd_rdy=0 SHALL be ignored; no queuing.
REQ-015 ISSUE (exactly one cycle): reg_req_out=1, reg_ack_out=0, reg_src_out=SRC_ID, reg_rd_wr_L_out/reg_addr_out = latched values, reg_data_out = latched write data (write) or 0 (read); then WAIT.
REQ-016 Outside ISSUE, reg_req_out and reg_ack_out SHALL be 0 and remaining ring outputs 0.
REQ-017 WAIT: a return matches when reg_req_in=1, reg_src_in=SRC_ID, reg_addr_in=latched addr; match SHALL move to RESP.
REQ-018 Matched return with reg_ack_in=1: rsp_status=00; rsp_data=reg_data_in for read, latched write data for write.
REQ-019 Matched return with reg_ack_in=0: rsp_status=01, rsp_data=32'hDEAD_BEEF (zero-extended/truncated to REG_DATA_WIDTH).
REQ-020 WAIT timer SHALL clear on ISSUE exit and increment each WAIT cycle; reaching TIMEOUT without match: rsp_status=10, rsp_data=DEAD_BEEF, move to RESP.
REQ-021 Match and timer reaching TIMEOUT in the same cycle: match SHALL win.
REQ-022 RESP (one cycle): rsp_valid=1 with rsp_data/rsp_status stable; cmd_rdy=0; then IDLE. rsp_data/rsp_status SHALL hold until next response.
REQ-023 Latency: command accepted cycle N -> reg_req_out cycle N+1; return captured cycle M -> rsp_valid cycle M+1; minimum accept-to-rsp_valid 3 cycles.
REQ-024 Any reg_req_in=1 that is not a match in WAIT, or arrives in IDLE/ISSUE/RESP, SHALL be discarded (never forwarded) and increment stray_cnt, saturating at 255.
REQ-025 Ring returns SHALL never be re-emitted on ring outputs; initiator is ring head and terminus.

Reset
REQ-026 reset=0 SHALL asynchronously force: state IDLE, cmd_rdy=1 on release, rsp_valid=0, rsp_data=0, rsp_status=00, all ring outputs 0, timer 0, stray_cnt 0.
REQ-027 Reset mid-transaction SHALL abort with no rsp_valid; a late return after release counts as stray.

Verification
REQ-028 Write addr=0x000100, data=0x12345678; ring acks after 5 cycles -> one reg_req_out pulse carrying those values, rsp_valid with status 00, rsp_data 0x12345678.
REQ-029 Read addr=0x000200; ring returns ack=1 data=0xCAFEF00D -> rsp_status 00, rsp_data 0xCAFEF00D, reg_data_out was 0 during ISSUE.
REQ-030 Read addr=0x7FFFFF; ring returns ack=0 -> rsp_status 01, rsp_data 0xDEADBEEF.
REQ-031 TIMEOUT=10, no return -> rsp_valid exactly 11 cycles after ISSUE, status 10, data 0xDEADBEEF; cmd_req during WAIT ignored.
REQ-032 Return with reg_src_in=1 (SRC_ID=0) in WAIT, then true return -> stray_cnt=1, response from true return; 300 strays in IDLE -> stray_cnt=255.
REQ-033 Assert reset in WAIT, release, then deliver the return -> no rsp_valid, stray_cnt=1, cmd_rdy=1.
